mac_execute: RTL

//  RISC-MGMT execute-stage extension for custom multiply/accumulate instructions.

---
 rtl/mac_execute.sv | 116 +++++++++++
 1 files changed

// File: rtl/mac_execute.sv
// Execute-stage MUL/MAC extension: iterative radix-2^RADIX_BITS shift-add multiplier
// with one architectural accumulator; single-cycle RDACC/CLRACC.
module mac_execute #(
  parameter int WORD_W     = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] rs_a,
  input  logic [WORD_W-1:0] rs_b,
  input  logic [4:0]        rd_sel,
  input  logic              flush,
  output logic              busy,
  output logic              exception,
  output logic              reg_w,
  output logic [WORD_W-1:0] reg_wdata,
  output logic              exmem_valid,
  output logic [4:0]        exmem_rd,
  output logic [WORD_W-1:0] exmem_result
);
  localparam int STEPS = WORD_W / RADIX_BITS;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [1:0] OP_MUL = 2'b00, OP_MAC = 2'b01, OP_RDACC = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rd;
  } req_t;

  state_t              state, state_n;
  req_t                req;
  logic [2*WORD_W-1:0] a_sh, prod, partial;
  logic [WORD_W-1:0]   b_q, acc, hold_data, res;
  logic [4:0]          hold_rd;
  logic [CW-1:0]       cnt;
  logic [WORD_W:0]     sum;
  logic                issue, pulse;

  assign issue   = (state == IDLE) && start && !flush;
  // multiplicand is pre-shifted each step, so the digit product lands at the right weight
  assign partial = a_sh * (2*WORD_W)'(b_q[RADIX_BITS-1:0]);
  assign sum     = {1'b0, acc} + {1'b0, prod[WORD_W-1:0]};
  assign pulse   = (state == DONE) && !flush;

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    case (state)
      IDLE: if (issue) begin
        busy    = !op[1];
        state_n = op[1] ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (flush)                 state_n = IDLE;
        else if (cnt == CW'(1))    state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (req.op)
      OP_MUL:   res = prod[WORD_W-1:0];
      OP_MAC:   res = sum[WORD_W-1:0];
      OP_RDACC: res = acc;
      default:  res = '0;
    endcase
  end

  // pulse outputs are combinational in DONE so a late flush can still squash them
  assign exmem_valid  = pulse;
  assign exmem_rd     = pulse ? req.rd : hold_rd;
  assign exmem_result = pulse ? res : hold_data;
  assign reg_wdata    = exmem_result;
  assign reg_w        = pulse && (req.rd != 5'd0);
  assign exception    = pulse && (req.op == OP_MAC) && sum[WORD_W];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      req       <= '0;
      a_sh      <= '0;
      b_q       <= '0;
      prod      <= '0;
      cnt       <= '0;
      acc       <= '0;
      hold_rd   <= '0;
      hold_data <= '0;
    end else begin
      state <= state_n;
      if (issue) begin
        req  <= '{op: op, rd: rd_sel};
        a_sh <= {{WORD_W{1'b0}}, rs_a};
        b_q  <= rs_b;
        prod <= '0;
        cnt  <= CW'(STEPS);
      end else if (state == CALC && !flush) begin
        prod <= prod + partial;
        a_sh <= a_sh << RADIX_BITS;
        b_q  <= b_q >> RADIX_BITS;
        cnt  <= cnt - CW'(1);
      end
      if (pulse) begin
        hold_rd   <= req.rd;
        hold_data <= res;
        if (req.op == OP_MAC)      acc <= sum[WORD_W-1:0];
        else if (req.op == 2'b11)  acc <= '0;
      end
    end
  end
endmodule
